// File: rtl/uart_pkg.sv
// Shared FSM state type and frame constants for the uart_tx_arbiter block.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_e;

    localparam int   FRAME_BITS_PAR   = 11;
    localparam int   FRAME_BITS_NOPAR = 10;
    localparam logic IDLE_LEVEL       = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/serial-side bundle of uart_tx_arbiter; master = producers + baud source, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic                      baud_tick;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic [NUM_REQ-1:0]        grant;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic                      tx;
    logic                      frame_done;

    modport master (
        output baud_tick, req, data_in,
        input  grant, grant_id, busy, tx, frame_done
    );

    modport slave (
        input  baud_tick, req, data_in,
        output grant, grant_id, busy, tx, frame_done
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] sel,
    output logic [ID_W-1:0]    sel_id
);

    logic            found_s;
    logic [ID_W-1:0] idx_s;

    // Scan from ptr upwards and keep the first active request.
    always_comb begin
        sel     = '0;
        sel_id  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                sel[idx_s] = 1'b1;
                sel_id     = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared UART transmitter. Define UART_ARB_PARITY_EN for the 11-bit
// odd-parity frame; the default build sends 10-bit frames without parity.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e             state_q,    state_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    ptr_q,      ptr_d;
    logic               busy_q,     busy_d;
    logic               tx_q,       tx_d;
    logic               done_q,     done_d;
    logic [DATA_W-1:0]  shift_q,    shift_d;
    logic [CNT_W-1:0]   bitcnt_q,   bitcnt_d;
    logic [NUM_REQ-1:0] sel_s;
    logic [ID_W-1:0]    sel_id_s;
    logic [DATA_W-1:0]  sel_byte_s;

`ifdef UART_ARB_PARITY_EN
    logic par_q, par_d;

    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~^d;
    endfunction
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req    (bus.req),
        .ptr    (ptr_q),
        .sel    (sel_s),
        .sel_id (sel_id_s)
    );

    // Byte of the requester the arbiter currently selects.
    always_comb begin
        sel_byte_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_byte_s = sel_byte_s | ({DATA_W{sel_s[i]}} & bus.data_in[i*DATA_W +: DATA_W]);
        end
    end

    // Next-state and next-output logic of the frame FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
`ifdef UART_ARB_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = IDLE_LEVEL;
                if (|bus.req) begin
                    grant_d    = sel_s;
                    grant_id_d = sel_id_s;
                    shift_d    = sel_byte_s;
                    busy_d     = 1'b1;
                    ptr_d      = (sel_id_s == ID_W'(NUM_REQ - 1)) ? '0 : sel_id_s + ID_W'(1);
`ifdef UART_ARB_PARITY_EN
                    par_d      = odd_parity(sel_byte_s);
`endif
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // A tick landing in the grant cycle is ignored so the start bit is a full period.
            ST_WAIT: begin
                if (bus.baud_tick && (grant_q == '0)) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_START: begin
                if (bus.baud_tick) begin
                    tx_d     = shift_q[0];
                    shift_d  = {1'b0, shift_q[DATA_W-1:1]};
                    bitcnt_d = '0;
                    state_d  = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bus.baud_tick) begin
                    if (bitcnt_q == LAST_BIT) begin
`ifdef UART_ARB_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = IDLE_LEVEL;
                        state_d = ST_STOP;
`endif
                    end else begin
                        tx_d     = shift_q[0];
                        shift_d  = {1'b0, shift_q[DATA_W-1:1]};
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_ARB_PARITY_EN
            ST_PARITY: begin
                if (bus.baud_tick) begin
                    tx_d    = IDLE_LEVEL;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bus.baud_tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            done_q     <= 1'b0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
`ifdef UART_ARB_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
`ifdef UART_ARB_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.tx         = tx_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of grants/frames plus multi-cycle corner sequences.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;
    localparam int W = 8;
`ifdef UART_ARB_PARITY_EN
    localparam int FB = FRAME_BITS_PAR;
`else
    localparam int FB = FRAME_BITS_NOPAR;
`endif

    typedef struct {
        logic        rst_before;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_id;
        logic [7:0]  byte_v;
        logic        par;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   tick_cnt = 0;
    logic last_tick = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; baud_tick is high for one cycle in every 16.
    task automatic cyc();
        last_tick = bus.baud_tick;
        @(posedge clk);
        #1;
        tick_cnt      = (tick_cnt + 1) % 16;
        bus.baud_tick = (tick_cnt == 0);
    endtask

    function automatic logic [15:0] frame_of(input logic [7:0] b, input logic p);
        logic [15:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_ARB_PARITY_EN
        f[9]  = p;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    task automatic wait_grant(output logic [3:0] g, output logic [1:0] id, output logic b, output int lat);
        g = '0; id = '0; b = 1'b0; lat = 0;
        for (int i = 1; i <= 64; i++) begin
            cyc();
            if (bus.grant != 4'b0000) begin
                g = bus.grant; id = bus.grant_id; b = bus.busy; lat = i;
                return;
            end
        end
    endtask

    // Records tx once per tick from the start bit up to frame_done.
    task automatic get_frame(output logic [15:0] bits, output int n, output logic glitch);
        bits = '0; n = 0; glitch = 1'b0;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (bus.frame_done) return;
            if (bus.grant != 4'b0000 || !bus.busy) glitch = 1'b1;
            if (last_tick && (n > 0 || bus.tx == 1'b0) && n < 16) begin
                bits[n] = bus.tx;
                n++;
            end
        end
        n = -1;
    endtask

    initial begin
        vec_t        v[9];
        logic [3:0]  g;
        logic [1:0]  id;
        logic        b;
        logic        gl;
        int          lat;
        int          n;
        int          m;
        logic [15:0] bits;

        v[0] = '{1'b0, 4'b0001, 32'h0000_00AA, 4'b0001, 2'd0, 8'hAA, 1'b1};
        v[1] = '{1'b1, 4'b1111, 32'hCC07_F055, 4'b0001, 2'd0, 8'h55, 1'b1};
        v[2] = '{1'b0, 4'b1111, 32'hCC07_F055, 4'b0010, 2'd1, 8'hF0, 1'b1};
        v[3] = '{1'b0, 4'b1111, 32'hCC07_F055, 4'b0100, 2'd2, 8'h07, 1'b0};
        v[4] = '{1'b0, 4'b1111, 32'hCC07_F055, 4'b1000, 2'd3, 8'hCC, 1'b1};
        v[5] = '{1'b0, 4'b1111, 32'hCC07_F055, 4'b0001, 2'd0, 8'h55, 1'b1};
        v[6] = '{1'b0, 4'b0010, 32'hCC07_0F55, 4'b0010, 2'd1, 8'h0F, 1'b1};
        v[7] = '{1'b0, 4'b1001, 32'h8007_0F00, 4'b1000, 2'd3, 8'h80, 1'b0};
        v[8] = '{1'b0, 4'b1001, 32'h8007_0F00, 4'b0001, 2'd0, 8'h00, 1'b1};

        bus.req = '0; bus.data_in = '0; bus.baud_tick = 1'b0;
        repeat (3) cyc();
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_grant_id", bus.grant_id, 2'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_frame_done", bus.frame_done, 1'b0);
        reset = 1'b1;
        cyc();

        for (int i = 0; i < 9; i++) begin
            if (v[i].rst_before) reset = 1'b0;
            bus.req = v[i].req;
            bus.data_in = v[i].data;
            if (v[i].rst_before) begin
                cyc(); cyc();
                reset = 1'b1;
            end
            wait_grant(g, id, b, lat);
            chk($sformatf("v%0d_grant", i), g, v[i].exp_grant);
            chk($sformatf("v%0d_grant_id", i), id, v[i].exp_id);
            chk($sformatf("v%0d_busy_at_grant", i), b, 1'b1);
            chk($sformatf("v%0d_grant_latency", i), lat, 1);
            get_frame(bits, n, gl);
            chk($sformatf("v%0d_frame_len", i), n, FB);
            chk($sformatf("v%0d_frame_bits", i), bits, frame_of(v[i].byte_v, v[i].par));
            chk($sformatf("v%0d_grant_pulse_busy_hold", i), gl, 1'b0);
            chk($sformatf("v%0d_busy_after_done", i), bus.busy, 1'b0);
        end
        bus.req = '0;

        // Requester 2 rises mid-frame: held off until frame_done, granted right after.
        bus.data_in = 32'h0000_003C;
        bus.req = 4'b0001;
        wait_grant(g, id, b, lat);
        chk("hold_first_grant", g, 4'b0001);
        gl = 1'b0; n = -1;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (i == 40) begin
                bus.req = 4'b0101;
                bus.data_in = 32'h005A_003C;
            end
            if (bus.frame_done) begin
                n = i;
                break;
            end
            if (bus.grant != 4'b0000) gl = 1'b1;
        end
        chk("hold_no_grant_while_busy", gl, 1'b0);
        chk("hold_frame_done_seen", (n >= 0), 1'b1);
        cyc();
        chk("hold_grant_after_done", bus.grant, 4'b0100);
        chk("hold_grant_id_after_done", bus.grant_id, 2'd2);
        bus.req = '0;
        get_frame(bits, n, gl);
        chk("hold_frame_bits", bits, frame_of(8'h5A, 1'b1));

        // Reset pulsed while the data bits are on the line.
        bus.data_in = 32'h0000_0000;
        bus.req = 4'b0010;
        wait_grant(g, id, b, lat);
        chk("mr_grant", g, 4'b0010);
        bus.req = '0;
        n = 0;
        for (int i = 0; i < 200 && n < 5; i++) begin
            cyc();
            if (last_tick) n++;
        end
        chk("mr_tx_low_in_data", bus.tx, 1'b0);
        #4;
        reset = 1'b0;
        #1;
        chk("mr_tx_async_high", bus.tx, 1'b1);
        chk("mr_busy_cleared", bus.busy, 1'b0);
        repeat (3) cyc();
        reset = 1'b1;
        gl = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (bus.frame_done || bus.busy) gl = 1'b1;
        end
        chk("mr_no_frame_done", gl, 1'b0);
        bus.data_in = 32'h0000_9100;
        bus.req = 4'b0110;
        wait_grant(g, id, b, lat);
        chk("mr_grant_from_zero", g, 4'b0010);
        chk("mr_grant_id_from_zero", id, 2'd1);
        bus.req = '0;
        get_frame(bits, n, gl);
        chk("mr_frame_bits", bits, frame_of(8'h91, 1'b0));

        // Tick in the grant cycle is ignored; start bit then lasts one full tick period.
        tick_cnt = 15;
        bus.data_in = 32'h0000_0055;
        bus.req = 4'b0001;
        cyc();
        chk("co_grant", bus.grant, 4'b0001);
        bus.req = '0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (bus.tx == 1'b0) begin
                n = i;
                break;
            end
        end
        chk("co_start_delay", n, 17);
        m = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (bus.tx == 1'b1) begin
                m = i;
                break;
            end
        end
        chk("co_start_len", m, 16);
        gl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (bus.frame_done) begin
                gl = 1'b1;
                break;
            end
        end
        chk("co_frame_done_seen", gl, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares one UART transmit line between `NUM_REQ` byte requesters.
- Selects a requester by round-robin, captures its byte, and serialises it as a start/data/parity/stop frame.
- Bit boundaries are paced by the baud generator's transmit tick.
- Sits between on-chip byte producers and the serial pin; its frame format matches the UART receiver (LSB first, odd parity, one stop bit).

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: data bits per frame.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `baud_tick`  in  1  one-`clk`-wide pulse per bit period (baud generator `intx`).
- `req`  in  `NUM_REQ`  per-requester request level; held with data until granted.
- `data_in`  in  `NUM_REQ*DATA_W`  requester i byte at `[i*DATA_W +: DATA_W]`.
- `grant`  out  `NUM_REQ`  one-hot, one-cycle pulse; the byte is captured that cycle.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the current or last granted requester.
- `busy`  out  1  high from the grant cycle to the end of the stop bit.
- `tx`  out  1  serial output, idle high.
- `frame_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, WAIT, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If any `req` bit is set, the rr arbiter picks the first requester at or after pointer `ptr`.
  - Registered `grant[i]`=1 for one cycle.
  - `grant_id`=i, shift register ← byte i, `busy`=1.
  - `ptr` ← (i+1) mod `NUM_REQ`; next state WAIT.
- WAIT: on `baud_tick`, `tx`←0 and next state START. Aligns the start bit to a full tick period.
- START: on tick, `tx`←d[0], `bitcnt`←0, next state DATA.
- DATA: on tick:
  - If `bitcnt`==`DATA_W`-1: `tx`←parity, next state PARITY.
  - Otherwise: `tx`←d[`bitcnt`+1], `bitcnt`++.
- PARITY: on tick, `tx`←1, next state STOP.
- STOP: on tick, `frame_done` pulses, `busy`←0, next state IDLE.
- Parity is odd: parity = ~^data, so data plus parity holds an odd number of ones.
- `req` changes while busy are ignored. A request dropped before its grant is lost with no error.
- In IDLE, `baud_tick` has no effect.
- A tick in the same cycle as the grant is not counted; WAIT waits for the next tick.

## Timing
- Reset values: `tx`=1, `grant`=0, `grant_id`=0, `busy`=0, `frame_done`=0, `ptr`=0, state IDLE.
- Reset asserted mid-frame: `tx` returns high asynchronously, the frame is aborted and no `frame_done` is produced.
- Grant latency: `grant` is high in the cycle after the edge on which IDLE samples `req`.
- Each serial bit lasts exactly one tick interval.
- Frame occupancy after the grant: WAIT (up to one tick interval), then 11 tick intervals. The tx-low edge to `frame_done` spans 11 ticks.
- Back-to-back frames: IDLE lasts at least one cycle after STOP. The next grant follows one cycle later.
- Fairness: while all requesters hold `req`, grants rotate 0,1,2,3,0…
- `data_in` is sampled only in the grant cycle.

## Configuration
- `UART_ARB_PARITY_EN` defined: 11-bit frame with the odd-parity bit, as above.
- `UART_ARB_PARITY_EN` undefined:
  - The PARITY state is removed; DATA goes to STOP, driving `tx`←1 on the last tick.
  - The frame is 10 bits.
  - `frame_done` comes 10 ticks after the start edge.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum;
  - `FRAME_BITS_PAR`=11 and `FRAME_BITS_NOPAR`=10;
  - `IDLE_LEVEL`=1'b1.
- Sub-module `rr_arbiter`, combinational: inputs `req` and `ptr`, outputs one-hot `sel` and `sel_id`.

## Test plan
- Reset, then `req`=0001 with byte 0xAA, tick every 16 clk → `grant`=0001 pulse; `tx` carries 0,0,1,0,1,0,1,0,1, parity 1, stop 1; `frame_done` after 11 ticks.
- `req`=1111 held, bytes 0x55/0xF0/0x07/0xCC → grants in order 0,1,2,3,0; parity bits 1,1,0,1 respectively.
- `req`[2] raised while a frame from requester 0 is in progress → no grant until `frame_done`; `grant`=0100 pulses in the first IDLE cycle after it.
- Reset pulsed low mid-DATA → `tx`=1 immediately, `busy`=0, no `frame_done`; the next request is granted to the lowest index ≥ 0.
- Tick coincident with the grant cycle → start bit begins on the following tick and lasts a full tick interval.
- Build without `UART_ARB_PARITY_EN`, byte 0x0F → 10-bit frame 0,1,1,1,1,0,0,0,0,1.
